// File: rtl/roll_scheduler.sv
// Roll sequencer for the dice/roulette display: pulls values from the shared RNG
// on a decelerating k^2*BASE schedule and keeps a short history of final results.
module roll_scheduler #(
    parameter int DATA_W     = 4,
    parameter int STEPS      = 24,
    parameter int BASE       = 1,
    parameter int HIST_DEPTH = 4,
    parameter int CNT_W      = 20
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_start,
    input  logic                          i_stop,
    output logic                          o_rng_req,
    input  logic                          i_rng_valid,
    input  logic [DATA_W-1:0]             i_rng_data,
    output logic [DATA_W-1:0]             o_value,
    output logic                          o_busy,
    output logic                          o_done,
    output logic [4:0]                    o_step,
    input  logic [$clog2(HIST_DEPTH)-1:0] i_hist_sel,
    output logic [DATA_W-1:0]             o_hist,
    output logic [$clog2(HIST_DEPTH):0]   o_hist_count
);

    localparam int SEL_W = $clog2(HIST_DEPTH);
    localparam logic [4:0]     LAST_STEP = 5'(STEPS);
    localparam logic [SEL_W:0] HIST_FULL = (SEL_W + 1)'(HIST_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [DATA_W-1:0]   value_nxt;
    logic [4:0]          step_nxt;
    logic [CNT_W-1:0]    timer;
    logic [CNT_W-1:0]    timer_nxt;
    logic [CNT_W-1:0]    gap_last;
    logic                stop_flag;
    logic                stop_nxt;
    logic                xfer;
    logic                push;
    logic [DATA_W-1:0]   hist [HIST_DEPTH];

    assign xfer = o_rng_req && i_rng_valid;

    // Last timer value of the gap following update o_step.
    assign gap_last = CNT_W'(o_step) * CNT_W'(o_step) * CNT_W'(BASE) - CNT_W'(1);

    always_comb begin
        state_nxt = state;
        value_nxt = o_value;
        step_nxt  = o_step;
        timer_nxt = timer;
        stop_nxt  = stop_flag;
        push      = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_nxt = REQ;
                    step_nxt  = '0;
                    stop_nxt  = 1'b0;
                end
            end
            REQ: begin
                if (i_stop) begin
                    stop_nxt = 1'b1;
                end
                if (xfer) begin
                    value_nxt = i_rng_data;
                    step_nxt  = o_step + 5'd1;
                    timer_nxt = '0;
                    // A stop raised in this same cycle still makes this transfer the last.
                    if (step_nxt == LAST_STEP || stop_flag || i_stop) begin
                        state_nxt = IDLE;
                        push      = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                timer_nxt = timer + CNT_W'(1);
                if (i_stop) begin
                    stop_nxt  = 1'b1;
                    state_nxt = REQ;
                end else if (timer == gap_last) begin
                    state_nxt = REQ;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            o_rng_req <= 1'b0;
            o_value   <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_step    <= '0;
            timer     <= '0;
            stop_flag <= 1'b0;
        end else begin
            state     <= state_nxt;
            o_rng_req <= (state_nxt == REQ);
            o_value   <= value_nxt;
            o_busy    <= (state_nxt != IDLE);
            o_done    <= push;
            o_step    <= step_nxt;
            timer     <= timer_nxt;
            stop_flag <= stop_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < HIST_DEPTH; i++) begin
                hist[SEL_W'(i)] <= '0;
            end
            o_hist_count <= '0;
        end else if (push) begin
            for (int unsigned i = HIST_DEPTH - 1; i > 0; i--) begin
                hist[SEL_W'(i)] <= hist[SEL_W'(i - 1)];
            end
            hist[0] <= value_nxt;
            if (o_hist_count != HIST_FULL) begin
                o_hist_count <= o_hist_count + (SEL_W + 1)'(1);
            end
        end
    end

    always_comb begin
        o_hist = '0;
        if ({1'b0, i_hist_sel} < o_hist_count) begin
            o_hist = hist[i_hist_sel];
        end
    end

endmodule

// File: tb/tb_roll_scheduler.sv
// Directed bench for roll_scheduler: schedule timing, stalls, early stop,
// history ordering, ignored restarts and asynchronous reset.
module tb_roll_scheduler;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       rng_req;
    logic       rng_valid;
    logic [3:0] rng_data;
    logic [3:0] value;
    logic       busy;
    logic       done;
    logic [4:0] step;
    logic [1:0] hist_sel;
    logic [3:0] hist;
    logic [2:0] hist_count;

    int         total;
    int         bad;
    int         xfers;
    logic [3:0] data_base;
    bit         auto_data;

    roll_scheduler #(
        .DATA_W    (4),
        .STEPS     (24),
        .BASE      (1),
        .HIST_DEPTH(4),
        .CNT_W     (20)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_stop      (stop),
        .o_rng_req   (rng_req),
        .i_rng_valid (rng_valid),
        .i_rng_data  (rng_data),
        .o_value     (value),
        .o_busy      (busy),
        .o_done      (done),
        .o_step      (step),
        .i_hist_sel  (hist_sel),
        .o_hist      (hist),
        .o_hist_count(hist_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // Advance one cycle (negedge to negedge), tracking generator transfers.
    task automatic step_cycle();
        bit x;
        x = rng_req && rng_valid;
        @(negedge clk);
        if (x) begin
            xfers++;
            if (auto_data) rng_data = data_base + 4'(xfers);
        end
    endtask

    task automatic begin_roll(input logic [3:0] base);
        data_base = base;
        xfers     = 0;
        auto_data = 1'b1;
        rng_data  = base;
        rng_valid = 1'b1;
        start     = 1'b1;
        step_cycle();
        start     = 1'b0;
    endtask

    task automatic run_to(input int n, input int budget, output bit ok);
        int c;
        c = 0;
        while (xfers < n && c < budget) begin
            step_cycle();
            c++;
        end
        ok = (xfers >= n);
    endtask

    task automatic quick_roll(input logic [3:0] v);
        auto_data = 1'b0;
        rng_valid = 1'b0;
        start     = 1'b1;
        step_cycle();
        start     = 1'b0;
        stop      = 1'b1;
        rng_valid = 1'b1;
        rng_data  = v;
        step_cycle();
        stop      = 1'b0;
        rng_valid = 1'b0;
        step_cycle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        step_cycle();
        total++;
        if ({rng_req, busy, done, value, step, hist_count} !== 16'h0) begin
            $display("FAIL reset_outputs: got req=%0b busy=%0b done=%0b value=%h step=%0d cnt=%0d, want all 0",
                     rng_req, busy, done, value, step, hist_count);
            bad++;
        end
        for (int i = 0; i < 4; i++) begin
            hist_sel = 2'(i);
            #1;
            total++;
            if (hist !== 4'h0) begin
                $display("FAIL reset_hist[%0d]: got %h want 0", i, hist);
                bad++;
            end
        end
        hist_sel = 2'd0;
    endtask

    task automatic test_full_roll();
        int g;
        int sum;
        sum = 0;
        begin_roll(4'h1);
        for (int k = 1; k <= 24; k++) begin
            step_cycle();
            if (k < 24) begin
                g = 0;
                while (!rng_req && g < 2000) begin
                    g++;
                    step_cycle();
                end
                sum += g;
                total++;
                if (g != k * k) begin
                    $display("FAIL full_gap[%0d]: got %0d cycles want %0d", k, g, k * k);
                    bad++;
                end
            end
        end
        total++;
        if (sum != 4324) begin
            $display("FAIL full_gap_sum: got %0d want 4324", sum);
            bad++;
        end
        total++;
        if (xfers != 24 || step !== 5'd24 || value !== 4'h8) begin
            $display("FAIL full_result: got xfers=%0d step=%0d value=%h want 24/24/8", xfers, step, value);
            bad++;
        end
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || rng_req !== 1'b0) begin
            $display("FAIL full_done: got done=%0b busy=%0b req=%0b want 1/0/0", done, busy, rng_req);
            bad++;
        end
        hist_sel = 2'd0;
        #1;
        total++;
        if (hist !== 4'h8 || hist_count !== 3'd1) begin
            $display("FAIL full_hist: got hist0=%h cnt=%0d want 8/1", hist, hist_count);
            bad++;
        end
        step_cycle();
        total++;
        if (done !== 1'b0) begin
            $display("FAIL full_done_pulse: got done=%0b on second cycle want 0", done);
            bad++;
        end
    endtask

    task automatic test_stall();
        int g;
        begin_roll(4'h1);
        step_cycle();
        rng_valid = 1'b0;
        step_cycle();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (rng_req !== 1'b1 || value !== 4'h1) begin
                $display("FAIL stall_hold[%0d]: got req=%0b value=%h want 1/1", i, rng_req, value);
                bad++;
            end
            step_cycle();
        end
        total++;
        if (rng_req !== 1'b1) begin
            $display("FAIL stall_req4: got req=%0b want 1", rng_req);
            bad++;
        end
        rng_valid = 1'b1;
        step_cycle();
        total++;
        if (value !== 4'h2 || step !== 5'd2 || rng_req !== 1'b0) begin
            $display("FAIL stall_xfer2: got value=%h step=%0d req=%0b want 2/2/0", value, step, rng_req);
            bad++;
        end
        g = 0;
        while (!rng_req && g < 100) begin
            g++;
            step_cycle();
        end
        total++;
        if (g != 4) begin
            $display("FAIL stall_gap: got %0d want 4", g);
            bad++;
        end
        stop = 1'b1;
        step_cycle();
        stop = 1'b0;
        total++;
        if (done !== 1'b1 || step !== 5'd3 || busy !== 1'b0 || value !== 4'h3) begin
            $display("FAIL stall_stop_end: got done=%0b step=%0d busy=%0b value=%h want 1/3/0/3",
                     done, step, busy, value);
            bad++;
        end
        step_cycle();
    endtask

    task automatic test_stop();
        bit ok;
        begin_roll(4'h1);
        run_to(5, 200, ok);
        total++;
        if (!ok) begin
            $display("FAIL stop_reach5: got xfers=%0d want 5", xfers);
            bad++;
        end
        step_cycle();
        step_cycle();
        stop = 1'b1;
        step_cycle();
        stop = 1'b0;
        total++;
        if (rng_req !== 1'b1 || busy !== 1'b1 || step !== 5'd5) begin
            $display("FAIL stop_req_rise: got req=%0b busy=%0b step=%0d want 1/1/5", rng_req, busy, step);
            bad++;
        end
        step_cycle();
        total++;
        if (done !== 1'b1 || step !== 5'd6 || value !== 4'h6 || busy !== 1'b0) begin
            $display("FAIL stop_end: got done=%0b step=%0d value=%h busy=%0b want 1/6/6/0", done, step, value, busy);
            bad++;
        end
        stop = 1'b1;
        step_cycle();
        stop = 1'b0;
        step_cycle();
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || rng_req !== 1'b0 || step !== 5'd6) begin
            $display("FAIL stop_idle_ignored: got done=%0b busy=%0b req=%0b step=%0d want 0/0/0/6",
                     done, busy, rng_req, step);
            bad++;
        end
    endtask

    task automatic test_history();
        logic [3:0] vals [5];
        logic [3:0] want [4];
        vals = '{4'h3, 4'h7, 4'hA, 4'hC, 4'hF};
        want = '{4'hF, 4'hC, 4'hA, 4'h7};
        for (int r = 0; r < 5; r++) quick_roll(vals[r]);
        total++;
        if (hist_count !== 3'd4 || step !== 5'd1 || value !== 4'hF) begin
            $display("FAIL hist_count: got cnt=%0d step=%0d value=%h want 4/1/F", hist_count, step, value);
            bad++;
        end
        for (int i = 0; i < 4; i++) begin
            hist_sel = 2'(i);
            #1;
            total++;
            if (hist !== want[i]) begin
                $display("FAIL hist_entry[%0d]: got %h want %h", i, hist, want[i]);
                bad++;
            end
        end
        hist_sel = 2'd0;
    endtask

    task automatic test_start_ignored();
        bit ok;
        begin_roll(4'h1);
        run_to(10, 1000, ok);
        step_cycle();
        step_cycle();
        start = 1'b1;
        step_cycle();
        start = 1'b0;
        total++;
        if (!ok || step !== 5'd10 || busy !== 1'b1 || rng_req !== 1'b0) begin
            $display("FAIL start_busy_ignored: got ok=%0b step=%0d busy=%0b req=%0b want 1/10/1/0",
                     ok, step, busy, rng_req);
            bad++;
        end
        run_to(24, 6000, ok);
        total++;
        if (!ok || step !== 5'd24 || done !== 1'b1 || value !== 4'h8) begin
            $display("FAIL start_busy_complete: got ok=%0b step=%0d done=%0b value=%h want 1/24/1/8",
                     ok, step, done, value);
            bad++;
        end
        step_cycle();
        rng_valid = 1'b0;
        start = 1'b1;
        stop  = 1'b1;
        step_cycle();
        start = 1'b0;
        stop  = 1'b0;
        total++;
        if (busy !== 1'b1 || rng_req !== 1'b1 || step !== 5'd0) begin
            $display("FAIL start_stop_idle: got busy=%0b req=%0b step=%0d want 1/1/0", busy, rng_req, step);
            bad++;
        end
        xfers     = 0;
        data_base = 4'h1;
        auto_data = 1'b1;
        rng_data  = 4'h1;
        rng_valid = 1'b1;
        step_cycle();
        total++;
        if (busy !== 1'b1 || step !== 5'd1 || done !== 1'b0) begin
            $display("FAIL start_stop_not_latched: got busy=%0b step=%0d done=%0b want 1/1/0", busy, step, done);
            bad++;
        end
    endtask

    task automatic test_reset_midroll();
        bit ok;
        bit done_seen;
        run_to(7, 500, ok);
        total++;
        if (!ok || step !== 5'd7) begin
            $display("FAIL rst_reach7: got ok=%0b step=%0d want 1/7", ok, step);
            bad++;
        end
        step_cycle();
        step_cycle();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({rng_req, busy, done, value, step, hist_count} !== 16'h0 || hist !== 4'h0) begin
            $display("FAIL rst_async: got req=%0b busy=%0b done=%0b value=%h step=%0d cnt=%0d hist=%h want all 0",
                     rng_req, busy, done, value, step, hist_count, hist);
            bad++;
        end
        done_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        rst_n = 1'b1;
        step_cycle();
        if (done) done_seen = 1'b1;
        total++;
        if (done_seen) begin
            $display("FAIL rst_no_done: got done pulse=1 want 0");
            bad++;
        end
        begin_roll(4'h5);
        run_to(24, 6000, ok);
        #1;
        total++;
        if (!ok || step !== 5'd24 || done !== 1'b1 || value !== 4'hC || hist_count !== 3'd1 || hist !== 4'hC) begin
            $display("FAIL rst_new_roll: got ok=%0b step=%0d done=%0b value=%h cnt=%0d hist=%h want 1/24/1/C/1/C",
                     ok, step, done, value, hist_count, hist);
            bad++;
        end
        step_cycle();
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        xfers     = 0;
        data_base = 4'h0;
        auto_data = 1'b1;
        rst_n     = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        rng_valid = 1'b0;
        rng_data  = 4'h0;
        hist_sel  = 2'd0;
        test_reset();
        test_full_roll();
        test_stall();
        test_stop();
        test_history();
        test_start_ignored();
        test_reset_midroll();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/roll_scheduler.md
Name: roll_scheduler

Overview:
- Sequences the shared random-number source for the dice/roulette display.
- Requests values from the external generator through a req/valid handshake and updates the displayed value on a decelerating schedule: the gap after update k is k²·BASE cycles.
- Ends a roll after STEPS updates, or early on i_stop.
- Keeps a history of the last HIST_DEPTH final results for the display/readback logic.

Parameters:
- DATA_W, 4, width of the random value and the display value
- STEPS, 24, number of updates in a full roll (1..31)
- BASE, 1, cycles per unit of the k² gap; STEPS²·BASE must fit in CNT_W bits
- HIST_DEPTH, 4, number of stored final results (power of 2, ≥2)
- CNT_W, 20, width of the gap timer

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  begins a roll; sampled only in IDLE
- i_stop  in  1  requests an early finish; sampled only while busy
- o_rng_req  out  1  request to the generator
- i_rng_valid  in  1  generator data valid; a transfer occurs when o_rng_req && i_rng_valid
- i_rng_data  in  DATA_W  generator data
- o_value  out  DATA_W  current display value
- o_busy  out  1  roll in progress (state != IDLE)
- o_done  out  1  one-cycle pulse when a roll finishes
- o_step  out  5  number of transfers in the current/last roll
- i_hist_sel  in  log2(HIST_DEPTH)  history index; 0 = newest
- o_hist  out  DATA_W  history entry selected by i_hist_sel (combinational read)
- o_hist_count  out  log2(HIST_DEPTH)+1  valid history entries; saturates at HIST_DEPTH

Behaviour:
- Interface: reset i_rst_n, asynchronous, active-low; clock i_clk.
- Reset values: state IDLE; o_rng_req, o_value, o_busy, o_done, o_step, timer, stop flag, all history entries and o_hist_count all 0. Reset mid-roll aborts immediately; no o_done pulse.
- All outputs except o_hist are registered.
- States are IDLE, REQ and WAIT.
- IDLE:
  - o_value holds the last result.
  - i_start=1 → REQ next cycle; o_step←0; stop flag cleared.
  - i_stop is ignored. If i_start and i_stop are asserted together, start wins.
- REQ:
  - o_rng_req=1, held until a transfer. o_value is unchanged while stalled.
  - On transfer: o_value←i_rng_data; o_step←o_step+1; timer←0.
  - If the new step == STEPS or the stop flag is set → finish. Otherwise → WAIT.
- WAIT:
  - o_rng_req=0; timer increments each cycle.
  - When timer == step·step·BASE−1 (step = o_step) → REQ. The gap after update k is therefore exactly k²·BASE cycles.
  - The product is computed at CNT_W width; no truncation is allowed given the parameter constraint.
- Finish (at the transfer edge):
  - State → IDLE; o_done=1 for exactly the following cycle.
  - The final value is pushed into the history: entry0 ← value, entry i ← entry i−1, the oldest entry is dropped.
  - o_hist_count increments, saturating at HIST_DEPTH.
- i_stop while busy:
  - Sets the stop flag.
  - In WAIT, the next state is REQ immediately; the gap is abandoned.
  - In REQ, the pending transfer becomes the final one.
  - Exactly one more transfer occurs after i_stop.
- i_start while busy is ignored; there is no restart.
- History reads: o_hist returns 0 for an index ≥ o_hist_count.
- o_step keeps its final value in IDLE until the next i_start.

Test Plan:
- Full roll with the generator always valid, data = 1,2,3,…: req cycles are single-cycle, with gaps of 1,4,9,…,529 cycles (sum 4324). Expect 24 transfers, o_value=24 mod 16=8, o_step=24, o_done one cycle after the last transfer, o_hist[0]=8, o_hist_count=1.
- Generator stall, valid delayed 3 cycles on transfer 2: o_rng_req is high for 4 cycles and o_value stays 1 until the transfer. The following gap is still 4 cycles.
- i_stop pulsed 2 cycles into the WAIT after step 5: req rises next cycle, transfer 6 ends the roll, o_step=6, o_done pulses once, a further i_stop is ignored.
- Five rolls with final values 3,7,A,C,F: o_hist[0..3]=F,C,A,7 and o_hist_count=4. Before any roll, o_hist=0 for all indices.
- i_start asserted during WAIT of step 10: no effect, and the roll completes at step 24. i_start together with i_stop in IDLE starts a roll.
- i_rst_n low during WAIT of step 7: all outputs 0 asynchronously, no o_done, history cleared. A new i_start after release runs a full roll.
